// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit difference/borrow cell used by the serial subtractor each CALC cycle.
module serial_sub_cell (
    input  logic a_k,
    input  logic b_k,
    input  logic br,
    output logic d_k,
    output logic br_next
);

    assign d_k     = a_k ^ b_k ^ br;
    assign br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, with valid/ready handshakes.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             d_k, br_next;

    serial_sub_cell u_cell (
        .a_k     (a_sh_reg[0]),
        .b_k     (b_sh_reg[0]),
        .br      (br_reg),
        .d_k     (d_k),
        .br_next (br_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt_reg == LAST_BIT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Working shift registers; the result register is only loaded on the final bit
    // so diff/bout never show partial results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        br_reg     <= bin;
                        res_sh_reg <= '0;
                        cnt_reg    <= '0;
                    end
                end
                CALC: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= {d_k, res_sh_reg[WIDTH-1:1]};
                    br_reg     <= br_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        diff_reg <= {d_k, res_sh_reg[WIDTH-1:1]};
                        bout_reg <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors, backpressure, reset, random stream.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    int         applied = 0;
    int         miscompares = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_accept_cyc = 0;
    int         prev_accept_cyc = 0;
    logic [W:0] exp_q[$];
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: borrow is the sign bit of the (W+1)-bit difference.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic [W:0] t;
        t = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        return t;
    endfunction

    // Monitor: latency on out_valid rise, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid)
                check("latency", 32'(cyc - last_accept_cyc), 32'(W));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {23'd0, bout, diff}, 32'hFFFF_FFFF);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("diff", 32'(diff), 32'(e[W-1:0]));
                    check("bout", 32'(bout), 32'(e[W]));
                    $display("result a->diff=0x%02h bout=%0b (want 0x%02h/%0b)", diff, bout, e[W-1:0], e[W]);
                end
            end
            prev_valid = out_valid;
        end
    end

    // Offer one operation; junk operands are driven while waiting to prove they are ignored.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input logic [W:0] expv, input bit push, input bit hold, input bit spacing);
        int n = 0;
        while (!in_ready && n < 200) begin
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            a = av;
            b = bv;
            bin = bi;
            if (push) begin
                exp_q.push_back(expv);
                applied++;
            end
            @(posedge clk); #1;
            prev_accept_cyc = last_accept_cyc;
            last_accept_cyc = cyc;
            if (spacing) check("accept_spacing", 32'(last_accept_cyc - prev_accept_cyc), 32'(W + 2));
            if (!hold) in_valid = 1'b0;
            $display("accept a=0x%02h b=0x%02h bin=%0b at cycle %0d", av, bv, bi, cyc);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results {bout, diff}.
        send(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E}, 1, 0, 0);
        send(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF}, 1, 0, 0);
        send(8'h80, 8'h7F, 1'b1, {1'b0, 8'h00}, 1, 0, 0);
        send(8'h00, 8'hFF, 1'b1, {1'b1, 8'h00}, 1, 0, 0);
        send(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, 1, 0, 0);
        send(8'hFF, 8'h00, 1'b0, {1'b0, 8'hFF}, 1, 0, 0);
        drain();

        // Backpressure: hold out_ready low in DONE while offering new operands.
        out_ready = 1'b0;
        send(8'h33, 8'h11, 1'b0, {1'b0, 8'h22}, 1, 0, 0);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff_hold", {23'd0, bout, diff}, {23'd0, 1'b0, 8'h22});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h10, 8'h20, 1'b1, {1'b1, 8'hEF}, 1, 0, 0);
        drain();

        // Reset during CALC discards the operation.
        send(8'h12, 8'h34, 1'b0, '0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", {23'd0, bout, diff}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hFF, 8'h0F, 1'b0, {1'b0, 8'hF0}, 1, 0, 0);
        drain();
        @(posedge clk); #1;

        // Back-to-back stream with in_valid held high and out_ready tied high.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbi;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom_range(0, 1));
            send(ra, rb, rbi, model(ra, rb, rbi), 1, 1, i > 0);
        end
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
